// File: rtl/fu_dispatch_pkg.sv
// Shared types for the dispatch stage: unit classes, operators, the dispatch
// register entry and the class-to-readiness helper.
package fu_dispatch_pkg;

  localparam int unsigned VLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 4;

  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC
  } fu_t;

  typedef enum logic [3:0] {
    ADD, SUB, MUL, LW, SW, BEQ, CSR_RW, SFENCE_VMA, FADD
  } fu_op;

  typedef struct packed {
    fu_t                      fu;
    fu_op                     operation;
    logic [VLEN-1:0]          operand_a;
    logic [VLEN-1:0]          operand_b;
    logic [VLEN-1:0]          imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    fu_t                fu;
    fu_data_t           fu_data;
    logic [VLEN-1:0]    rs1;
    logic [VLEN-1:0]    rs2;
    logic [VLEN-1:0]    pc;
    logic               is_compressed;
    branchpredict_sbe_t bp;
  } dispatch_entry_t;

  // Classes served by the fixed-latency unit share flu_ready_i.
  function automatic logic fu_needs_flu(fu_t fu);
    return fu inside {ALU, CTRL_FLOW, CSR, MULT};
  endfunction

endpackage

// File: rtl/fu_dispatch_if.sv
// Issue-side handshake and execute-side strobes/data of the dispatch stage.
interface fu_dispatch_if;
  import fu_dispatch_pkg::*;

  logic               issue_valid_i;
  logic               issue_ready_o;
  fu_t                issue_fu_i;
  fu_data_t           issue_data_i;
  logic [VLEN-1:0]    issue_rs1_i;
  logic [VLEN-1:0]    issue_rs2_i;
  logic [VLEN-1:0]    issue_pc_i;
  logic               issue_is_compressed_i;
  branchpredict_sbe_t issue_bp_i;

  fu_data_t           fu_data_o;
  logic [VLEN-1:0]    rs1_forwarding_o;
  logic [VLEN-1:0]    rs2_forwarding_o;
  logic [VLEN-1:0]    pc_o;
  logic               is_compressed_instr_o;
  branchpredict_sbe_t branch_predict_o;

  logic               alu_valid_o;
  logic               branch_valid_o;
  logic               csr_valid_o;
  logic               mult_valid_o;
  logic               lsu_valid_o;
  logic               fpu_valid_o;

  logic               flu_ready_i;
  logic               lsu_ready_i;
  logic               fpu_ready_i;
  logic               stall_o;

  modport slave (
    input  issue_valid_i, issue_fu_i, issue_data_i, issue_rs1_i, issue_rs2_i,
           issue_pc_i, issue_is_compressed_i, issue_bp_i,
           flu_ready_i, lsu_ready_i, fpu_ready_i,
    output issue_ready_o, fu_data_o, rs1_forwarding_o, rs2_forwarding_o, pc_o,
           is_compressed_instr_o, branch_predict_o,
           alu_valid_o, branch_valid_o, csr_valid_o, mult_valid_o,
           lsu_valid_o, fpu_valid_o, stall_o
  );

  modport master (
    output issue_valid_i, issue_fu_i, issue_data_i, issue_rs1_i, issue_rs2_i,
           issue_pc_i, issue_is_compressed_i, issue_bp_i,
           flu_ready_i, lsu_ready_i, fpu_ready_i,
    input  issue_ready_o, fu_data_o, rs1_forwarding_o, rs2_forwarding_o, pc_o,
           is_compressed_instr_o, branch_predict_o,
           alu_valid_o, branch_valid_o, csr_valid_o, mult_valid_o,
           lsu_valid_o, fpu_valid_o, stall_o
  );
endinterface

// File: rtl/fu_dispatch.sv
// Single-entry dispatch register between issue and execute; also owns the
// fixed-latency writeback port schedule (MULT result blocks FLU classes).
module fu_dispatch (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          flush_i,
  fu_dispatch_if.slave  io
);
  import fu_dispatch_pkg::*;

  logic            r_full;
  logic            r_mult_wb;
  logic            r_sfence_hold;
  dispatch_entry_t r_entry;

  logic            w_unit_ready;
  logic            w_wb_block;
  logic            w_fire;
  logic            w_issue_ready;
  logic            w_accept;
  dispatch_entry_t w_new;

  always_comb begin
    w_unit_ready = 1'b0;
    if (fu_needs_flu(r_entry.fu)) begin
      w_unit_ready = io.flu_ready_i;
    end else begin
      case (r_entry.fu)
        LOAD, STORE:  w_unit_ready = io.lsu_ready_i;
        FPU, FPU_VEC: w_unit_ready = io.fpu_ready_i;
        NONE:         w_unit_ready = 1'b1;
        default:      w_unit_ready = 1'b0;
      endcase
    end
  end

  // MULT owns the shared writeback port the cycle after it fires.
  assign w_wb_block    = r_mult_wb & (r_entry.fu inside {ALU, CTRL_FLOW, CSR});
  assign w_fire        = r_full & w_unit_ready & ~r_sfence_hold & ~w_wb_block & ~flush_i;
  assign w_issue_ready = (~r_full | w_fire) & ~flush_i;
  assign w_accept      = io.issue_valid_i & w_issue_ready;

  always_comb begin
    w_new               = '0;
    w_new.fu            = io.issue_fu_i;
    w_new.fu_data       = io.issue_data_i;
    w_new.rs1           = io.issue_rs1_i;
    w_new.rs2           = io.issue_rs2_i;
    w_new.pc            = io.issue_pc_i;
    w_new.is_compressed = io.issue_is_compressed_i;
    w_new.bp            = io.issue_bp_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_full        <= 1'b0;
      r_mult_wb     <= 1'b0;
      r_sfence_hold <= 1'b0;
      r_entry       <= '0;
    end else if (clr_i) begin
      r_full        <= 1'b0;
      r_mult_wb     <= 1'b0;
      r_sfence_hold <= 1'b0;
      r_entry       <= '0;
    end else begin
      if (flush_i)       r_full <= 1'b0;
      else if (w_accept) r_full <= 1'b1;
      else if (w_fire)   r_full <= 1'b0;
      if (w_accept) r_entry <= w_new;
      r_mult_wb     <= w_fire & (r_entry.fu == MULT);
      r_sfence_hold <= w_fire & (r_entry.fu == CSR)
                       & (r_entry.fu_data.operation == SFENCE_VMA);
    end
  end

  always_comb begin
    io.alu_valid_o    = 1'b0;
    io.branch_valid_o = 1'b0;
    io.csr_valid_o    = 1'b0;
    io.mult_valid_o   = 1'b0;
    io.lsu_valid_o    = 1'b0;
    io.fpu_valid_o    = 1'b0;
    if (w_fire) begin
      case (r_entry.fu)
        ALU:          io.alu_valid_o    = 1'b1;
        CTRL_FLOW:    io.branch_valid_o = 1'b1;
        CSR:          io.csr_valid_o    = 1'b1;
        MULT:         io.mult_valid_o   = 1'b1;
        LOAD, STORE:  io.lsu_valid_o    = 1'b1;
        FPU, FPU_VEC: io.fpu_valid_o    = 1'b1;
        default:      ;
      endcase
    end
  end

  assign io.issue_ready_o         = w_issue_ready;
  assign io.stall_o               = r_full & ~w_fire & ~flush_i;
  assign io.fu_data_o             = r_entry.fu_data;
  assign io.rs1_forwarding_o      = r_entry.rs1;
  assign io.rs2_forwarding_o      = r_entry.rs2;
  assign io.pc_o                  = r_entry.pc;
  assign io.is_compressed_instr_o = r_entry.is_compressed;
  assign io.branch_predict_o      = r_entry.bp;

endmodule

// File: tb/tb_fu_dispatch.sv
// Directed bench for fu_dispatch: inputs change on the falling edge, outputs
// are sampled 1 time unit later, state advances on the rising edge.
module tb_fu_dispatch;
  import fu_dispatch_pkg::*;

  localparam logic [5:0] S_NO  = 6'b000000;
  localparam logic [5:0] S_ALU = 6'b100000;
  localparam logic [5:0] S_BR  = 6'b010000;
  localparam logic [5:0] S_CSR = 6'b001000;
  localparam logic [5:0] S_MUL = 6'b000100;
  localparam logic [5:0] S_LSU = 6'b000010;
  localparam logic [5:0] S_FPU = 6'b000001;

  localparam logic [2:0] R_ALL = 3'b111;  // {flu, lsu, fpu}

  logic clk_i = 1'b0;
  logic rst_ni;
  logic clr_i;
  logic flush_i;
  int   n_chk = 0;
  int   n_err = 0;

  fu_dispatch_if bus ();

  fu_dispatch dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .flush_i (flush_i),
    .io      (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] strb();
    return {bus.alu_valid_o, bus.branch_valid_o, bus.csr_valid_o,
            bus.mult_valid_o, bus.lsu_valid_o, bus.fpu_valid_o};
  endfunction

  task automatic cyc(input logic v, input fu_t fu, input fu_op op, input int id,
                     input logic [2:0] rdy, input logic fl, input logic cl);
    fu_data_t d;
    @(negedge clk_i);
    d              = '0;
    d.fu           = fu;
    d.operation    = op;
    d.trans_id     = id[TRANS_ID_BITS-1:0];
    d.operand_a    = 64'(id);
    bus.issue_valid_i         = v;
    bus.issue_fu_i            = fu;
    bus.issue_data_i          = d;
    bus.issue_rs1_i           = 64'(id + 100);
    bus.issue_rs2_i           = 64'(id + 200);
    bus.issue_pc_i            = 64'(id * 4);
    bus.issue_is_compressed_i = id[0];
    bus.issue_bp_i            = '0;
    bus.flu_ready_i           = rdy[2];
    bus.lsu_ready_i           = rdy[1];
    bus.fpu_ready_i           = rdy[0];
    flush_i                   = fl;
    clr_i                     = cl;
    #1;
  endtask

  task automatic idle(input logic [2:0] rdy);
    cyc(1'b0, NONE, ADD, 0, rdy, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] tid();
    return 64'(bus.fu_data_o.trans_id);
  endfunction

  initial begin
    rst_ni = 1'b0;
    clr_i = 1'b0;
    flush_i = 1'b0;
    bus.issue_valid_i = 1'b0;
    bus.issue_fu_i = NONE;
    bus.issue_data_i = '0;
    bus.issue_rs1_i = '0;
    bus.issue_rs2_i = '0;
    bus.issue_pc_i = '0;
    bus.issue_is_compressed_i = 1'b0;
    bus.issue_bp_i = '0;
    bus.flu_ready_i = 1'b1;
    bus.lsu_ready_i = 1'b1;
    bus.fpu_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_strobes", 64'(strb()), 64'(S_NO));
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    chk("rst_tid", tid(), 64'd0);
    chk("rst_pc", bus.pc_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.issue_ready_o), 64'd1);

    // Back-to-back ALU 1,2,3
    cyc(1, ALU, ADD, 1, R_ALL, 0, 0);
    chk("b2b_empty", 64'(strb()), 64'(S_NO));
    chk("b2b_rdy0", 64'(bus.issue_ready_o), 64'd1);
    cyc(1, ALU, ADD, 2, R_ALL, 0, 0);
    chk("b2b_alu1", 64'(strb()), 64'(S_ALU));
    chk("b2b_id1", tid(), 64'd1);
    chk("b2b_rdy1", 64'(bus.issue_ready_o), 64'd1);
    cyc(1, ALU, ADD, 3, R_ALL, 0, 0);
    chk("b2b_alu2", 64'(strb()), 64'(S_ALU));
    chk("b2b_id2", tid(), 64'd2);
    chk("b2b_rdy2", 64'(bus.issue_ready_o), 64'd1);
    idle(R_ALL);
    chk("b2b_alu3", 64'(strb()), 64'(S_ALU));
    chk("b2b_id3", tid(), 64'd3);
    idle(R_ALL);
    chk("b2b_drain", 64'(strb()), 64'(S_NO));
    chk("b2b_nostall", 64'(bus.stall_o), 64'd0);

    // MULT 4 then ALU 5
    cyc(1, MULT, MUL, 4, R_ALL, 0, 0);
    cyc(1, ALU, ADD, 5, R_ALL, 0, 0);
    chk("ma_mul", 64'(strb()), 64'(S_MUL));
    chk("ma_mul_id", tid(), 64'd4);
    idle(R_ALL);
    chk("ma_block", 64'(strb()), 64'(S_NO));
    chk("ma_stall", 64'(bus.stall_o), 64'd1);
    chk("ma_rdy", 64'(bus.issue_ready_o), 64'd0);
    idle(R_ALL);
    chk("ma_alu", 64'(strb()), 64'(S_ALU));
    chk("ma_alu_id", tid(), 64'd5);
    idle(R_ALL);

    // MULT 6, MULT 7, ALU 8
    cyc(1, MULT, MUL, 6, R_ALL, 0, 0);
    cyc(1, MULT, MUL, 7, R_ALL, 0, 0);
    chk("mma_mul6", 64'(strb()), 64'(S_MUL));
    cyc(1, ALU, ADD, 8, R_ALL, 0, 0);
    chk("mma_mul7", 64'(strb()), 64'(S_MUL));
    chk("mma_id7", tid(), 64'd7);
    idle(R_ALL);
    chk("mma_block", 64'(strb()), 64'(S_NO));
    chk("mma_stall", 64'(bus.stall_o), 64'd1);
    idle(R_ALL);
    chk("mma_alu", 64'(strb()), 64'(S_ALU));
    chk("mma_id8", tid(), 64'd8);
    idle(R_ALL);

    // LOAD 9 held 5 cycles on lsu_ready=0, ALU 10 waiting upstream
    cyc(1, LOAD, LW, 9, 3'b101, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, ALU, ADD, 10, 3'b101, 0, 0);
      chk("ld_hold_strb", 64'(strb()), 64'(S_NO));
      chk("ld_hold_id", tid(), 64'd9);
      chk("ld_hold_rs1", bus.rs1_forwarding_o, 64'd109);
      chk("ld_hold_rdy", 64'(bus.issue_ready_o), 64'd0);
      chk("ld_hold_stall", 64'(bus.stall_o), 64'd1);
    end
    cyc(1, ALU, ADD, 10, R_ALL, 0, 0);
    chk("ld_fire", 64'(strb()), 64'(S_LSU));
    chk("ld_fire_id", tid(), 64'd9);
    chk("ld_fire_rdy", 64'(bus.issue_ready_o), 64'd1);
    idle(R_ALL);
    chk("ld_next_alu", 64'(strb()), 64'(S_ALU));
    chk("ld_next_id", tid(), 64'd10);
    idle(R_ALL);

    // SFENCE_VMA 11 then STORE 12
    cyc(1, CSR, SFENCE_VMA, 11, R_ALL, 0, 0);
    cyc(1, STORE, SW, 12, R_ALL, 0, 0);
    chk("sf_csr", 64'(strb()), 64'(S_CSR));
    idle(R_ALL);
    chk("sf_hold", 64'(strb()), 64'(S_NO));
    chk("sf_stall", 64'(bus.stall_o), 64'd1);
    idle(R_ALL);
    chk("sf_store", 64'(strb()), 64'(S_LSU));
    chk("sf_store_id", tid(), 64'd12);
    idle(R_ALL);

    // FPU 13 stalled, then flush while the unit becomes ready
    cyc(1, FPU, FADD, 13, 3'b110, 0, 0);
    idle(3'b110);
    chk("fl_wait", 64'(strb()), 64'(S_NO));
    chk("fl_wait_stall", 64'(bus.stall_o), 64'd1);
    cyc(0, NONE, ADD, 0, R_ALL, 1, 0);
    chk("fl_nofire", 64'(strb()), 64'(S_NO));
    chk("fl_rdy_low", 64'(bus.issue_ready_o), 64'd0);
    chk("fl_stall_low", 64'(bus.stall_o), 64'd0);
    idle(R_ALL);
    chk("fl_after", 64'(strb()), 64'(S_NO));
    chk("fl_after_rdy", 64'(bus.issue_ready_o), 64'd1);
    chk("fl_after_stall", 64'(bus.stall_o), 64'd0);

    // clr_i mid-stall discards LOAD 14
    cyc(1, LOAD, LW, 14, 3'b101, 0, 0);
    cyc(0, NONE, ADD, 0, 3'b101, 0, 1);
    chk("clr_stall", 64'(bus.stall_o), 64'd1);
    idle(R_ALL);
    chk("clr_nofire", 64'(strb()), 64'(S_NO));
    chk("clr_rdy", 64'(bus.issue_ready_o), 64'd1);
    chk("clr_tid", tid(), 64'd0);
    chk("clr_pc", bus.pc_o, 64'd0);

    // NONE drains without a strobe
    cyc(1, NONE, ADD, 15, 3'b000, 0, 0);
    idle(3'b000);
    chk("none_strb", 64'(strb()), 64'(S_NO));
    chk("none_stall", 64'(bus.stall_o), 64'd0);
    chk("none_rdy", 64'(bus.issue_ready_o), 64'd1);
    chk("none_pc", bus.pc_o, 64'd60);

    // MULT then CTRL_FLOW: branch blocked one cycle
    cyc(1, MULT, MUL, 1, R_ALL, 0, 0);
    cyc(1, CTRL_FLOW, BEQ, 2, R_ALL, 0, 0);
    chk("mb_mul", 64'(strb()), 64'(S_MUL));
    idle(R_ALL);
    chk("mb_block", 64'(strb()), 64'(S_NO));
    idle(R_ALL);
    chk("mb_branch", 64'(strb()), 64'(S_BR));
    idle(R_ALL);

    // MULT then LOAD: load is not blocked
    cyc(1, MULT, MUL, 5, R_ALL, 0, 0);
    cyc(1, LOAD, LW, 6, R_ALL, 0, 0);
    chk("ml_mul", 64'(strb()), 64'(S_MUL));
    idle(R_ALL);
    chk("ml_load", 64'(strb()), 64'(S_LSU));
    chk("ml_load_id", tid(), 64'd6);
    idle(R_ALL);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
